// File: rtl/karatsuba_stream.sv
// karatsuba_stream: word-serial operand loader and product streamer around an external karatsuba multiplier
// Optional feature macro KARATSUBA_STREAM_OVERLAP_EN lets loading of the next operands overlap the current send.
module karatsuba_stream #(
   parameter int N       = 512,
   parameter int W       = 32,
   parameter int MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_last,
   output logic [N-1:0]     mul_a,
   output logic [N-1:0]     mul_b,
   input  logic [2*N-1:0]   mul_c
);
   localparam int K  = N / W;
   localparam int R  = 2 * N / W;
   localparam int CW = $clog2(R);
`ifdef KARATSUBA_STREAM_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif
   // PEND is the send-wait state without overlap and the capture-hold state with overlap
   typedef enum logic [1:0] {LOAD_A, LOAD_B, WAIT, PEND} state_t;
   state_t state_q, state_d;
   logic [CW-1:0]  k_q, k_d, o_q, o_d;
   logic [3:0]     w_q, w_d;
   logic           send_q, send_d, last_q, last_d;
   logic [N-1:0]   a_q, a_d, b_q, b_d;
   logic [2*N-1:0] res_q, res_d;
   logic           in_hs, out_hs, done, cap;
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;
   assign done     = out_hs && last_q;
   assign mul_a    = a_q;
   assign mul_b    = b_q;
   assign out_data = res_q[W-1:0];
   assign out_last = last_q;
   // state and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= LOAD_A;
         k_q     <= '0;
         w_q     <= '0;
         o_q     <= '0;
         send_q  <= 1'b0;
         last_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         w_q     <= w_d;
         o_q     <= o_d;
         send_q  <= send_d;
         last_q  <= last_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end
   // load FSM next state: word counting, settle countdown and product capture decision
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      w_d     = w_q;
      cap     = 1'b0;
      case (state_q)
         LOAD_A, LOAD_B: if (in_hs) begin
            k_d = (k_q == CW'(K-1)) ? '0 : k_q + 1'b1;
            if (k_q == CW'(K-1)) begin
               state_d = (state_q == LOAD_A) ? LOAD_B : WAIT;
               w_d     = 4'(MUL_LAT);
            end
         end
         WAIT: if (w_q == 4'd1) begin
            cap     = !(OVL && send_q);
            state_d = (OVL && !send_q) ? LOAD_A : PEND;
         end else begin
            w_d = w_q - 1'b1;
         end
         PEND: begin
            cap = OVL && !send_q;
            if (OVL ? !send_q : done) state_d = LOAD_A;
         end
      endcase
   end
   // operand writes, result capture and output shifting
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      res_d  = res_q;
      o_d    = o_q;
      send_d = send_q;
      last_d = last_q;
      if (in_hs && state_q == LOAD_A) a_d[k_q*W +: W] = in_data;
      if (in_hs && state_q == LOAD_B) b_d[k_q*W +: W] = in_data;
      if (out_hs) begin
         res_d  = res_q >> W;
         o_d    = done ? '0 : o_q + 1'b1;
         last_d = (o_q == CW'(R-2));
         send_d = !done;
      end
      if (cap) begin
         res_d  = mul_c;
         o_d    = '0;
         last_d = 1'b0;
         send_d = 1'b1;
      end
   end
   // handshake outputs decoded from state
   always_comb begin
      in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
      out_valid = send_q;
   end
endmodule

// File: tb/tb_karatsuba_stream.sv
// tb_karatsuba_stream: randomized and directed checks of karatsuba_stream at MUL_LAT 2, 1 and 15
module tb_karatsuba_stream;
   localparam int N  = 16;
   localparam int W  = 4;
   localparam int K  = N / W;
   localparam int R  = 2 * N / W;
   localparam int PW = 2 * N;
   logic clk = 1'b0;
   logic rst_n;
   logic [2:0] iv, ir, ov, orr, ol;
   logic [2:0][W-1:0]  id, od;
   logic [2:0][N-1:0]  ma, mb;
   logic [2:0][PW-1:0] mc;
   int total = 0;
   int bad   = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : gd
      karatsuba_stream #(.N(N), .W(W), .MUL_LAT(g == 0 ? 2 : g == 1 ? 1 : 15)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .in_valid(iv[g]), .in_ready(ir[g]), .in_data(id[g]),
         .out_valid(ov[g]), .out_ready(orr[g]), .out_data(od[g]), .out_last(ol[g]),
         .mul_a(ma[g]), .mul_b(mb[g]), .mul_c(mc[g]));
      assign mc[g] = PW'(ma[g]) * PW'(mb[g]);
   end
   function automatic int lat(int d);
      return d == 0 ? 2 : d == 1 ? 1 : 15;
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic put(int d, logic [W-1:0] x, bit gap);
      int n = 0;
      if (gap) repeat ($urandom_range(0, 2)) begin
         iv[d] = 1'b0;
         step();
      end
      iv[d] = 1'b1;
      id[d] = x;
      while (!ir[d] && n < 200) begin
         step();
         n++;
      end
      chk("in_ready_timeout", 64'(ir[d]), 64'(1));
      step();
      iv[d] = 1'b0;
   endtask
   task automatic load(int d, logic [N-1:0] a, logic [N-1:0] b, bit gap);
      for (int i = 0; i < K; i++) put(d, a[i*W +: W], gap);
      for (int i = 0; i < K; i++) put(d, b[i*W +: W], gap);
   endtask
   task automatic take(int d, logic [PW-1:0] p, int stall);
      logic [W-1:0] hold;
      int n;
      orr[d] = 1'b1;
      for (int i = 0; i < R; i++) begin
         n = 0;
         while (!ov[d] && n < 200) begin
            step();
            n++;
         end
         chk("out_valid", 64'(ov[d]), 64'(1));
`ifndef KARATSUBA_STREAM_OVERLAP_EN
         chk("in_ready_send", 64'(ir[d]), 64'(0));
`endif
         if (i == stall) begin
            orr[d] = 1'b0;
            hold = od[d];
            repeat (5) begin
               step();
               chk("stall_data", 64'(od[d]), 64'(hold));
               chk("stall_valid", 64'(ov[d]), 64'(1));
            end
            orr[d] = 1'b1;
         end
         chk("out_data", 64'(od[d]), 64'(p[i*W +: W]));
         chk("out_last", 64'(ol[d]), 64'(i == R - 1));
         step();
      end
      orr[d] = 1'b0;
      chk("idle_after_last", 64'(ov[d]), 64'(0));
   endtask
   task automatic xact(int d, logic [N-1:0] a, logic [N-1:0] b, bit gap, int stall);
      logic [PW-1:0] p;
      p = PW'(a) * PW'(b);
      load(d, a, b, gap);
      for (int c = 0; c < lat(d); c++) begin
         chk("wait_valid", 64'(ov[d]), 64'(0));
         chk("wait_ready", 64'(ir[d]), 64'(0));
         chk("wait_mul_a", 64'(ma[d]), 64'(a));
         chk("wait_mul_b", 64'(mb[d]), 64'(b));
         step();
      end
      chk("first_valid", 64'(ov[d]), 64'(1));
      take(d, p, stall);
   endtask
   initial begin
      logic [N-1:0] a1, b1, a2, b2;
      rst_n = 1'b0;
      iv = '0;
      orr = '0;
      id = '0;
      repeat (3) step();
      rst_n = 1'b1;
      for (int d = 0; d < 3; d++) begin
         chk("rst_in_ready", 64'(ir[d]), 64'(1));
         chk("rst_out_valid", 64'(ov[d]), 64'(0));
         chk("rst_out_data", 64'(od[d]), 64'(0));
         chk("rst_out_last", 64'(ol[d]), 64'(0));
         chk("rst_mul_a", 64'(ma[d]), 64'(0));
         chk("rst_mul_b", 64'(mb[d]), 64'(0));
      end
      xact(0, 16'hFFFF, 16'hFFFF, 1'b0, -1);
      xact(0, 16'h00FF, 16'h0101, 1'b0, -1);
      xact(0, 16'h1234, 16'h0000, 1'b0, -1);
      xact(0, 16'($urandom), 16'($urandom), 1'b1, 3);
      xact(0, 16'($urandom), 16'($urandom), 1'b1, 3);
      for (int i = 0; i < 5; i++) put(0, 4'($urandom), 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_in_ready", 64'(ir[0]), 64'(1));
      chk("mid_rst_out_valid", 64'(ov[0]), 64'(0));
      chk("mid_rst_out_data", 64'(od[0]), 64'(0));
      chk("mid_rst_out_last", 64'(ol[0]), 64'(0));
      chk("mid_rst_mul_a", 64'(ma[0]), 64'(0));
      chk("mid_rst_mul_b", 64'(mb[0]), 64'(0));
      xact(0, 16'h0002, 16'h0003, 1'b0, -1);
      for (int i = 0; i < 100; i++) xact(1, 16'($urandom), 16'($urandom), 1'b0, -1);
      for (int i = 0; i < 100; i++) xact(2, 16'($urandom), 16'($urandom), 1'b0, -1);
`ifdef KARATSUBA_STREAM_OVERLAP_EN
      a1 = 16'($urandom);
      b1 = 16'($urandom);
      a2 = 16'($urandom);
      b2 = 16'($urandom);
      orr[0] = 1'b0;
      load(0, a1, b1, 1'b0);
      repeat (lat(0) + 1) step();
      chk("ovl_send_valid", 64'(ov[0]), 64'(1));
      chk("ovl_ready_in_send", 64'(ir[0]), 64'(1));
      load(0, a2, b2, 1'b1);
      repeat (lat(0) + 2) step();
      chk("ovl_hold_ready", 64'(ir[0]), 64'(0));
      chk("ovl_hold_mul_a", 64'(ma[0]), 64'(a2));
      chk("ovl_hold_mul_b", 64'(mb[0]), 64'(b2));
      take(0, PW'(a1) * PW'(b1), -1);
      take(0, PW'(a2) * PW'(b2), -1);
`else
      a1 = '0;
      b1 = '0;
      a2 = '0;
      b2 = '0;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
